// File: rtl/game_state_regfile.sv
// CPU-writable game state register bank feeding packed bullet, sprite and health buses to the display.
// Define GAME_STATE_FRAME_SYNC_EN for shadow/commit double buffering at screenEnd; otherwise writes drive the buses directly.
module game_state_regfile #(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          MAX_BULLETS = 64,
    parameter logic [31:0] INIT_HEALTH = 32'd3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [31:0]               wrData,
    input  logic                      we,
    input  logic                      re,
    output logic [31:0]               rdData,
    input  logic                      screenEnd,
    output logic [32*MAX_BULLETS-1:0] allBulletContents,
    output logic [127:0]              allSpriteContents,
    output logic [63:0]               allHealthContents,
    output logic [31:0]               frameCount
);
    localparam int          NUM_WORDS = MAX_BULLETS + 6;
    localparam int          IDX_W     = $clog2(NUM_WORDS);
    localparam logic [31:0] FC_ADDR   = 32'(MAX_BULLETS + 6);
    localparam logic [31:0] ST_ADDR   = 32'(MAX_BULLETS + 7);

    function automatic logic [31:0] reset_word(input int unsigned i);
        return (i == 32'(MAX_BULLETS + 4) || i == 32'(MAX_BULLETS + 5)) ? INIT_HEALTH : '0;
    endfunction

    logic [31:0]      addr_ext;
    logic             writable;
    logic [IDX_W-1:0] idx;
    logic             status_rd;
    logic [31:0]      read_word;
    logic             frame_tick;
    logic [31:0]      shadow  [NUM_WORDS];
    logic [31:0]      visible [NUM_WORDS];

    assign addr_ext  = 32'(addr);
    assign writable  = addr_ext < 32'(NUM_WORDS);
    assign idx       = addr_ext[IDX_W-1:0];
    assign status_rd = re && (addr_ext == ST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                shadow[i] <= reset_word(i);
            end
        end else if (we && writable) begin
            shadow[idx] <= wrData;
        end
    end

`ifdef GAME_STATE_FRAME_SYNC_EN
    logic [31:0] committed [NUM_WORDS];

    // Commit samples the shadow before this edge, so a same-cycle write waits for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                committed[i] <= reset_word(i);
            end
        end else if (screenEnd) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                committed[i] <= shadow[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            visible[i] = committed[i];
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            visible[i] = shadow[i];
        end
    end
`endif

    // A commit in the same cycle as a status read keeps the tick set.
    always_ff @(posedge clk) begin
        if (reset) begin
            frameCount <= '0;
            frame_tick <= 1'b0;
        end else if (screenEnd) begin
            frameCount <= frameCount + 32'd1;
            frame_tick <= 1'b1;
        end else if (status_rd) begin
            frame_tick <= 1'b0;
        end
    end

    always_comb begin
        read_word = '0;
        if (writable) begin
            read_word = shadow[idx];
        end else if (addr_ext == FC_ADDR) begin
            read_word = frameCount;
        end else if (addr_ext == ST_ADDR) begin
            read_word = {31'd0, frame_tick};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdData <= '0;
        end else if (re) begin
            rdData <= read_word;
        end
    end

    for (genvar j = 0; j < MAX_BULLETS; j++) begin : g_bullet
        assign allBulletContents[32*j +: 32] = visible[j];
    end

    for (genvar k = 0; k < 4; k++) begin : g_sprite
        assign allSpriteContents[32*k +: 32] = visible[MAX_BULLETS + k];
    end

    assign allHealthContents = {visible[MAX_BULLETS + 5], visible[MAX_BULLETS + 4]};

endmodule

// File: tb/tb_game_state_regfile.sv
// Randomised and directed bench for game_state_regfile against a word-map reference model.
module tb_game_state_regfile;
    localparam int MB = 64;
    localparam int NW = MB + 6;
    localparam int FC = MB + 6;
    localparam int ST = MB + 7;
    localparam logic [31:0] W5 = {10'd100, 9'd200, 10'd0, 1'b1, 2'b0};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [11:0]       addr = '0;
    logic [31:0]       wrData = '0;
    logic              we = 1'b0;
    logic              re = 1'b0;
    logic              screenEnd = 1'b0;
    logic [31:0]       rdData;
    logic [32*MB-1:0]  allBulletContents;
    logic [127:0]      allSpriteContents;
    logic [63:0]       allHealthContents;
    logic [31:0]       frameCount;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b1;

    game_state_regfile #(.ADDR_WIDTH(12), .MAX_BULLETS(MB), .INIT_HEALTH(32'd3)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wrData(wrData), .we(we), .re(re),
        .rdData(rdData), .screenEnd(screenEnd), .allBulletContents(allBulletContents),
        .allSpriteContents(allSpriteContents), .allHealthContents(allHealthContents),
        .frameCount(frameCount)
    );

    always #5 clk = ~clk;

    // Reference model: word array for CPU view, separate array for what the display sees.
    logic [31:0] m_sh [NW];
    logic [31:0] m_cm [NW];
    logic [31:0] m_fc, m_rd;
    logic        m_tick;

    always @(posedge clk) begin : model
        int unsigned a;
        a = addr;
        if (reset) begin
            for (int i = 0; i < NW; i++) begin
                m_sh[i] = (i == MB + 4 || i == MB + 5) ? 32'd3 : 32'd0;
                m_cm[i] = m_sh[i];
            end
            m_fc = 0; m_tick = 0; m_rd = 0;
        end else begin
            if (re) begin
                if (a < NW)       m_rd = m_sh[a];
                else if (a == FC) m_rd = m_fc;
                else if (a == ST) m_rd = {31'd0, m_tick};
                else              m_rd = 0;
            end
            if (screenEnd) begin
                m_cm = m_sh;
                m_fc = m_fc + 1;
                m_tick = 1;
            end else if (re && a == ST) begin
                m_tick = 0;
            end
            if (we && a < NW) m_sh[a] = wrData;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] vis(input int i);
`ifdef GAME_STATE_FRAME_SYNC_EN
        return m_cm[i];
`else
        return m_sh[i];
`endif
    endfunction

    task automatic chk_words(input string name, input int base, input int n, input logic [2047:0] bus);
        int bad;
        logic [31:0] got;
        bad = -1;
        for (int j = 0; j < n; j++) begin
            if (bad < 0 && bus[32*j +: 32] !== vis(base + j)) bad = j;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            got = bus[32*bad +: 32];
            $display("FAIL %s word %0d: got %h expected %h at %0t", name, bad, got, vis(base + bad), $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdData", rdData, m_rd);
            chk("frameCount", frameCount, m_fc);
            chk_words("bullets", 0, MB, 2048'(allBulletContents));
            chk_words("sprites", MB, 4, 2048'(allSpriteContents));
            chk_words("health", MB + 4, 2, 2048'(allHealthContents));
        end
    end

    task automatic step(input logic w, input logic r, input int a, input logic [31:0] d,
                        input logic s, input logic rst);
        we = w; re = r; addr = 12'(a); wrData = d; screenEnd = s; reset = rst;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        idle(); idle();
        chk("rst bullets lo", allBulletContents[31:0], 32'd0);
        chk("rst bullets hi", allBulletContents[2047:2016], 32'd0);
        chk("rst sprite", allSpriteContents[31:0], 32'd0);
        chk("rst health p1", allHealthContents[31:0], 32'd3);
        chk("rst health p2", allHealthContents[63:32], 32'd3);
        chk("rst frameCount", frameCount, 32'd0);
        chk("rst rdData", rdData, 32'd0);

        step(1, 0, 64, 32'h50, 0, 0);
        step(0, 1, 64, 0, 0, 0);
        chk("read x1", rdData, 32'h50);
`ifdef GAME_STATE_FRAME_SYNC_EN
        chk("x1 before commit", allSpriteContents[31:0], 32'd0);
`else
        chk("x1 direct", allSpriteContents[31:0], 32'h50);
`endif
        step(0, 0, 0, 0, 1, 0);
        chk("x1 after commit", allSpriteContents[31:0], 32'h50);

        step(1, 0, 5, W5, 1, 0);
`ifdef GAME_STATE_FRAME_SYNC_EN
        chk("bullet5 same-cycle", allBulletContents[191:160], 32'd0);
        step(0, 0, 0, 0, 1, 0);
`endif
        chk("bullet5 committed", allBulletContents[191:160], W5);

        step(0, 0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        step(0, 1, ST, 0, 0, 0);
        chk("status first", rdData, 32'd1);
        step(0, 1, ST, 0, 0, 0);
        chk("status second", rdData, 32'd0);
        step(0, 1, FC, 0, 0, 0);
        chk("frameCount read", rdData, 32'd3);
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, ST, 0, 1, 0);
        chk("status with commit", rdData, 32'd1);
        step(0, 1, ST, 0, 0, 0);
        chk("tick survives", rdData, 32'd1);
        chk("frameCount 5", frameCount, 32'd5);

        step(1, 0, 100, 32'hFFFF_FFFF, 0, 0);
        step(0, 1, 100, 0, 0, 0);
        chk("unmapped read", rdData, 32'd0);
        step(0, 0, 0, 0, 1, 0);
        chk("unmapped bullets", allBulletContents[31:0], 32'd0);
        chk("unmapped sprite", allSpriteContents[31:0], 32'd0);
        chk("unmapped health", allHealthContents[31:0], 32'd3);
        step(1, 0, FC, 32'd5, 0, 0);
        chk("frameCount ro", frameCount, 32'd6);
        step(0, 1, FC, 0, 0, 0);
        chk("frameCount ro read", rdData, 32'd6);

        step(1, 0, 69, 32'd0, 0, 0);
`ifdef GAME_STATE_FRAME_SYNC_EN
        chk("p2 uncommitted", allHealthContents[63:32], 32'd3);
`else
        chk("p2 direct", allHealthContents[63:32], 32'd0);
`endif
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        chk("p2 after reset", allHealthContents[63:32], 32'd3);
        chk("frameCount after reset", frameCount, 32'd1);

        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(1)), 1'($urandom_range(1)),
                 ($urandom_range(7) == 0) ? int'($urandom_range(4095)) : int'($urandom_range(NW + 3)),
                 $urandom, ($urandom_range(7) == 0), ($urandom_range(199) == 0));
        end
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/game_state_regfile.md
Name: game_state_regfile

Overview:
- Memory-mapped register bank written by the CPU's load/store path; produces the packed bullet, sprite and health buses consumed by the display controller.
- Holds a CPU-writable shadow copy and a display-visible committed copy; the committed copy updates only at the frame boundary (screenEnd), so a frame never tears.
- Provides registered CPU readback, a frame counter and a clear-on-read frame-tick status so software can pace game updates to the display.

Parameters:
- ADDR_WIDTH, 12, width of the CPU word address.
- MAX_BULLETS, 64, number of 32-bit bullet words. Fixes allBulletContents width = 32*MAX_BULLETS.
- INIT_HEALTH, 3, reset value of both health words.

Ports:
- clk  input  1  system clock, same clock as the display controller.
- reset  input  1  synchronous, active-high reset.
- addr  input  ADDR_WIDTH  CPU word address.
- wrData  input  32  CPU write data.
- we  input  1  write enable, sampled at the rising clk edge.
- re  input  1  read enable, sampled at the rising clk edge.
- rdData  output  32  read data, valid the cycle after re.
- screenEnd  input  1  one-cycle pulse between frames, from the timing generator.
- allBulletContents  output  32*MAX_BULLETS  committed bullet words; word j occupies bits [32j+31:32j].
- allSpriteContents  output  128  committed x1, y1, x2, y2 words; word k occupies bits [32k+31:32k].
- allHealthContents  output  64  committed p1 health [31:0] and p2 health [63:32].
- frameCount  output  32  number of commits since reset.

Behaviour:
- Word map:
  - 0..MAX_BULLETS-1: bullet words. Field layout: x [31:22], y [21:13], active [2]. All 32 bits are stored verbatim.
  - MAX_BULLETS..+3: sprite words x1, y1, x2, y2.
  - MAX_BULLETS+4 and +5: p1 health, p2 health.
  - MAX_BULLETS+6: frameCount, read-only.
  - MAX_BULLETS+7: status, read-only. Bit0 = frameTick, other bits read 0.
- Writes:
  - we=1 with a writable address: the shadow word takes wrData at that edge.
  - Writes to read-only or unmapped addresses are ignored.
- Reads:
  - re=1: rdData at the next cycle holds the shadow word for the address (frameCount/status for the read-only words).
  - Unmapped addresses return 0.
  - rdData holds its value while re=0.
  - we and re together at the same address: rdData returns the pre-write value.
- Commit:
  - On an edge with screenEnd=1, every committed word takes the shadow value as it was before that edge.
  - A write in the same cycle as screenEnd lands in the shadow only and is committed at the next screenEnd.
  - On each commit, frameCount increments by 1 (wraps 0xFFFFFFFF to 0) and frameTick is set.
- frameTick:
  - Cleared by an re to the status address; the read returns the value before clearing.
  - Set and clear in the same cycle: set wins, and the read returns the pre-edge value.
- Reset:
  - Shadow and committed bullet and sprite words = 0.
  - Both health words = INIT_HEALTH, shadow and committed.
  - frameCount = 0, frameTick = 0, rdData = 0.
  - Reset wins over we, re and screenEnd in the same cycle.
  - Reset mid-frame discards all uncommitted writes.
- Latency: write to display-visible output is 1 cycle after the next screenEnd edge. Read latency is 1 cycle.
- Outputs are driven directly from registers; there is no combinational path from CPU inputs to the bus outputs.

Optional Feature:
- Macro: GAME_STATE_FRAME_SYNC_EN.
- Defined: behaviour exactly as above (shadow/commit double buffering).
- Not defined:
  - No shadow copy; a single register set drives the outputs and readback.
  - A write is visible on the output buses 1 cycle after the write edge.
  - screenEnd still increments frameCount and sets frameTick.

Test Plan:
- Reset, then idle 2 cycles -> all buses 0 except allHealthContents = {32'd3, 32'd3}; frameCount = 0; rdData = 0.
- Write addr 64 = 0x00000050, then re at addr 64 -> rdData = 0x50 the next cycle. allSpriteContents[31:0] stays 0 until a screenEnd pulse, and reads 0x50 from the cycle after it.
- Write addr 5 = {10'd100, 9'd200, 10'd0, 1'b1, 2'b0} in the same cycle as screenEnd -> bits [191:160] stay 0 after that commit and equal the written word after the second screenEnd.
- 3 screenEnd pulses, then re at addr 71 twice -> first read 1, second read 0; re at addr 70 returns 3. Pulse screenEnd in the same cycle as a status read -> read returns the old value and frameTick remains 1.
- Write addr 100 = 0xFFFFFFFF, re at addr 100 -> rdData = 0 and no bus changes after screenEnd. Write addr 70 = 5 -> frameCount is unchanged.
- Write addr 69 = 0, then reset before any screenEnd, then screenEnd -> allHealthContents[63:32] = 3. With GAME_STATE_FRAME_SYNC_EN undefined, the same write makes [63:32] = 0 one cycle after the write edge, with no screenEnd.
